// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter for the shared 32-bit data bus.
// Drives one-hot grant vectors into the tristate driver enables and inserts a
// dead turnaround cycle between bus owners.
// Optional watchdog: define BUS_ARB_TIMEOUT_EN to revoke grants held longer
// than TIMEOUT cycles (timeout_err pulses for the forced TURN cycle).
module bus_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int OWNER_W     = 2,
    parameter int TIMEOUT     = 15,
    parameter int CNT_W       = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [NUM_MASTERS-1:0] done,
    output logic [NUM_MASTERS-1:0] grant,
    output logic [OWNER_W-1:0]     owner,
    output logic                   bus_busy,
    output logic                   timeout_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    if (NUM_MASTERS < 2 || OWNER_W != $clog2(NUM_MASTERS) || TIMEOUT >= (1 << CNT_W)) begin : g_param_check
        $error("bus_arbiter: illegal parameter combination");
    end

    state_t                   state_q, state_d;
    logic [NUM_MASTERS-1:0]   grant_q, grant_d;
    logic [OWNER_W-1:0]       owner_q, owner_d;
    logic [OWNER_W-1:0]       last_q, last_d;
    logic [OWNER_W-1:0]       sel;
    logic [OWNER_W-1:0]       idx;
    logic                     any_req;
    logic                     release_c;
    logic                     timeout_hit;

    // Round-robin pick: scan offsets from the far end down so the requester
    // closest after the last owner is the one left in sel.
    always_comb begin
        any_req = 1'b0;
        sel     = '0;
        idx     = '0;
        for (int i = NUM_MASTERS; i >= 1; i--) begin
            idx = OWNER_W'((int'(last_q) + i) % NUM_MASTERS);
            if (req[idx]) begin
                any_req = 1'b1;
                sel     = idx;
            end
        end
    end

    // The owner gives up the bus by strobing done or dropping its request.
    assign release_c = done[owner_q] || !req[owner_q];

`ifdef BUS_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q;
    logic             terr_q;

    assign timeout_hit = ((cnt_q + CNT_W'(1)) == CNT_W'(TIMEOUT));

    // Watchdog: counter sits at zero outside GRANT, so it restarts on every
    // new tenure; the error flag marks the TURN cycle of a forced release.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            terr_q <= 1'b0;
        end else begin
            cnt_q  <= (state_q == GRANT) ? cnt_q + CNT_W'(1) : '0;
            terr_q <= (state_q == GRANT) && !release_c && timeout_hit;
        end
    end

    assign timeout_err = terr_q;
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Next-state and next-output logic for the IDLE/GRANT/TURN sequence.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE, TURN: begin
                if (any_req) begin
                    grant_d = NUM_MASTERS'(1) << sel;
                    owner_d = sel;
                    last_d  = sel;
                    state_d = GRANT;
                end else begin
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (release_c || timeout_hit) begin
                    grant_d = '0;
                    state_d = TURN;
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset clears the bus immediately.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            last_q  <= OWNER_W'(NUM_MASTERS - 1);
        end else begin
            // NOTE: non-blocking assignments so all registers update from pre-edge values.
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    assign grant    = grant_q;
    assign owner    = owner_q;
    assign bus_busy = |grant_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed, table-driven bench for bus_arbiter (4 masters).
// Inputs change 1 time unit after each rising edge; outputs are sampled there too.
module tb_bus_arbiter;

    logic       clock;
    logic       reset_n;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] grant;
    logic [1:0] owner;
    logic       bus_busy;
    logic       timeout_err;

    int n_total = 0;
    int n_pass  = 0;
    int viol    = 0;

    typedef struct {
        logic [3:0] req;
        logic [3:0] done;
        logic [3:0] grant;
        logic [1:0] owner;
    } vec_t;

    vec_t vecs[25];

    bus_arbiter #(
        .NUM_MASTERS(4),
        .OWNER_W    (2),
        .TIMEOUT    (15),
        .CNT_W      (4)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req        (req),
        .done       (done),
        .grant      (grant),
        .owner      (owner),
        .bus_busy   (bus_busy),
        .timeout_err(timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Invariants on every cycle: at most one grant, busy tracks grant, and no
    // owner-to-owner switch without a zero cycle in between.
    logic [3:0] prev_grant = '0;
    always @(negedge clock) begin
        if (reset_n) begin
            if ($countones(grant) > 1) viol++;
            if (bus_busy !== (|grant)) viol++;
            if (prev_grant != 4'b0 && grant != 4'b0 && grant != prev_grant) viol++;
        end
        prev_grant = grant;
    end

    initial begin
        int bad;
        reset_n = 1'b0;
        req     = '0;
        done    = '0;

        // Round-robin, wrap/priority and non-owner cases, starting from IDLE with last=3.
        vecs[0]  = '{4'b1111, 4'b0000, 4'b0001, 2'd0};
        vecs[1]  = '{4'b1111, 4'b0001, 4'b0000, 2'd0};
        vecs[2]  = '{4'b1111, 4'b0000, 4'b0010, 2'd1};
        vecs[3]  = '{4'b1111, 4'b0010, 4'b0000, 2'd1};
        vecs[4]  = '{4'b1111, 4'b0000, 4'b0100, 2'd2};
        vecs[5]  = '{4'b1111, 4'b0100, 4'b0000, 2'd2};
        vecs[6]  = '{4'b1111, 4'b0000, 4'b1000, 2'd3};
        vecs[7]  = '{4'b1111, 4'b1000, 4'b0000, 2'd3};
        vecs[8]  = '{4'b1111, 4'b0000, 4'b0001, 2'd0};
        vecs[9]  = '{4'b1111, 4'b0001, 4'b0000, 2'd0};
        vecs[10] = '{4'b1000, 4'b0000, 4'b1000, 2'd3};
        vecs[11] = '{4'b1001, 4'b1000, 4'b0000, 2'd3};
        vecs[12] = '{4'b1001, 4'b0000, 4'b0001, 2'd0};
        vecs[13] = '{4'b1001, 4'b0001, 4'b0000, 2'd0};
        vecs[14] = '{4'b1001, 4'b0000, 4'b1000, 2'd3};
        vecs[15] = '{4'b0000, 4'b0000, 4'b0000, 2'd3};
        vecs[16] = '{4'b0000, 4'b0000, 4'b0000, 2'd3};
        vecs[17] = '{4'b0000, 4'b0000, 4'b0000, 2'd3};
        vecs[18] = '{4'b0010, 4'b0000, 4'b0010, 2'd1};
        vecs[19] = '{4'b0010, 4'b0101, 4'b0010, 2'd1};
        vecs[20] = '{4'b0011, 4'b0101, 4'b0010, 2'd1};
        vecs[21] = '{4'b0001, 4'b0000, 4'b0000, 2'd1};
        vecs[22] = '{4'b0001, 4'b0000, 4'b0001, 2'd0};
        vecs[23] = '{4'b0000, 4'b0000, 4'b0000, 2'd0};
        vecs[24] = '{4'b0000, 4'b0000, 4'b0000, 2'd0};

        // Reset state
        #2;
        check("reset_grant", 32'(grant), 32'h0);
        check("reset_owner", 32'(owner), 32'h0);
        check("reset_busy", 32'(bus_busy), 32'h0);
        check("reset_terr", 32'(timeout_err), 32'h0);
        step();
        reset_n = 1'b1;

        // Single master: grant one cycle after request, held until done.
        req = 4'b0100;
        step();
        check("single_grant", 32'(grant), 32'h4);
        check("single_owner", 32'(owner), 32'h2);
        check("single_busy", 32'(bus_busy), 32'h1);
        for (int i = 0; i < 4; i++) begin
            step();
            check("single_hold", 32'(grant), 32'h4);
        end
        done = 4'b0100;
        req  = 4'b0000;
        step();
        check("single_release", 32'(grant), 32'h0);
        check("single_owner_turn", 32'(owner), 32'h2);
        done = 4'b0000;
        step();
        check("single_idle", 32'(grant), 32'h0);

        // Asynchronous reset in the middle of a tenure.
        req = 4'b1111;
        step();
        check("pre_reset_grant", 32'(grant), 32'h8);
        check("pre_reset_owner", 32'(owner), 32'h3);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_grant", 32'(grant), 32'h0);
        check("async_busy", 32'(bus_busy), 32'h0);
        check("async_owner", 32'(owner), 32'h0);
        #3;
        reset_n = 1'b1;
        step();
        check("post_reset_grant", 32'(grant), 32'h1);
        check("post_reset_owner", 32'(owner), 32'h0);

        // Return to a clean IDLE with last=3 for the table.
        req     = 4'b0000;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;

        for (int i = 0; i < 25; i++) begin
            req  = vecs[i].req;
            done = vecs[i].done;
            step();
            check($sformatf("vec%0d_grant", i), 32'(grant), 32'(vecs[i].grant));
            check($sformatf("vec%0d_owner", i), 32'(owner), 32'(vecs[i].owner));
            check($sformatf("vec%0d_busy", i), 32'(bus_busy), 32'(|vecs[i].grant));
        end
        done = 4'b0000;

        // Watchdog: master 1 requests forever without done.
        req = 4'b0010;
        step();
        check("wd_grant", 32'(grant), 32'h2);
`ifdef BUS_ARB_TIMEOUT_EN
        bad = 0;
        for (int i = 0; i < 14; i++) begin
            step();
            if (grant !== 4'b0010 || timeout_err !== 1'b0) bad++;
        end
        check("wd_hold_15", 32'(bad), 32'h0);
        step();
        check("wd_revoke_grant", 32'(grant), 32'h0);
        check("wd_revoke_err", 32'(timeout_err), 32'h1);
        step();
        check("wd_regrant", 32'(grant), 32'h2);
        check("wd_err_pulse", 32'(timeout_err), 32'h0);
`else
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (grant !== 4'b0010 || timeout_err !== 1'b0) bad++;
        end
        check("nowd_hold_100", 32'(bad), 32'h0);
        check("nowd_terr", 32'(timeout_err), 32'h0);
`endif
        req = 4'b0000;
        step();
        check("wd_final_release", 32'(grant), 32'h0);
        step();

        check("invariants", 32'(viol), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
